// File: rtl/dsd_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
//   state_e    : arbiter FSM encoding (IDLE / GRANT / GAP)
//   NO_GRANT_N : active-low grant bank value when nobody owns the decoder
//   RST_LAST   : priority pointer after reset (requester 0 wins first)
//   dec2to4_n  : active-low 2-to-4 decode of a select value
package dsd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam logic [3:0] NO_GRANT_N = 4'hF;
  localparam logic [1:0] RST_LAST   = 2'd3;

  function automatic logic [3:0] dec2to4_n(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/rr_decoder_arbiter_pick4.sv
// rr_pick4: combinational round-robin priority picker for four requesters.
//   req   : level requests, bit i = requester i
//   last  : index of the most recent owner (lowest priority this round)
//   idx   : chosen requester, searched last+1, last+2, last+3, last (mod 4)
//   valid : 1 when any request is present
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: shares one 2-to-4 decoder bank between four requesters.
//   clk, rst : system clock, synchronous active-high reset
//   req      : level requests from the four sources
//   A, B     : registered decoder select (owner index bits 1 and 0)
//   En_n     : active-low decoder enable, low only in GRANT
//   grant_n  : active-low one-hot grant (decoder output), 4'hF when idle
//   busy     : high in GRANT and GAP
//   timeout  : one-cycle pulse in the GAP following a forced release
// Each owner holds at most MAX_HOLD cycles and is followed by a one-cycle
// dead gap plus an IDLE cycle before the next grant.
module rr_decoder_arbiter
  import dsd_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       A,
  output logic       B,
  output logic       En_n,
  output logic [3:0] grant_n,
  output logic       busy,
  output logic       timeout
);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic              en_n_q, en_n_d;
  logic [3:0]        grant_n_q, grant_n_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        last_q, last_d;

  logic [1:0]        pick_idx;
  logic              pick_valid;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    en_n_d    = en_n_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    last_d    = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          en_n_d  = 1'b0;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        // The owner is always last_q while granted; a dropped request wins
        // over the hold limit so a coincident release is reported voluntary.
        if (!req[last_q]) begin
          state_d = GAP;
          en_n_d  = 1'b1;
        end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = GAP;
          en_n_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        en_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    grant_n_d = en_n_d ? NO_GRANT_N : dec2to4_n(sel_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      en_n_q    <= 1'b1;
      grant_n_q <= NO_GRANT_N;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      last_q    <= RST_LAST;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_n_q    <= en_n_d;
      grant_n_q <= grant_n_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

  assign A       = sel_q[1];
  assign B       = sel_q[0];
  assign En_n    = en_n_q;
  assign grant_n = grant_n_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter with MAX_HOLD = 8.
module tb_rr_decoder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       A, B, En_n, busy, timeout;
  logic [3:0] grant_n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  rr_decoder_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .A       (A),
    .B       (B),
    .En_n    (En_n),
    .grant_n (grant_n),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full output vector: {A,B}, En_n, grant_n, busy, timeout
  task automatic check_all(input string tag, input logic [1:0] ab, input logic en_n,
                           input logic [3:0] gn, input logic bsy, input logic tmo);
    check({tag, ".AB"},      {2'b00, A, B},    {2'b00, ab});
    check({tag, ".En_n"},    {3'b000, En_n},   {3'b000, en_n});
    check({tag, ".grant_n"}, grant_n,          gn);
    check({tag, ".busy"},    {3'b000, busy},   {3'b000, bsy});
    check({tag, ".timeout"}, {3'b000, timeout},{3'b000, tmo});
  endtask

  function automatic logic [3:0] gn_of(input logic [1:0] o);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << o);
  endfunction

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset with all requests asserted
    rst = 1'b1;
    req = 4'hF;
    step();
    step();
    check_all("reset", 2'b00, 1'b1, 4'hF, 1'b0, 1'b0);

    rst = 1'b0;
    step();
    check_all("first_grant", 2'b00, 1'b0, 4'b1110, 1'b1, 1'b0);
    req = 4'h0;
    step();
    check_all("first_gap", 2'b00, 1'b1, 4'hF, 1'b1, 1'b0);
    step();
    check_all("first_idle", 2'b00, 1'b1, 4'hF, 1'b0, 1'b0);

    // Voluntary release after three cycles
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("vol_grant%0d", i), 2'b10, 1'b0, 4'b1011, 1'b1, 1'b0);
    end
    req = 4'h0;
    step();
    check_all("vol_gap", 2'b10, 1'b1, 4'hF, 1'b1, 1'b0);
    step();
    check_all("vol_idle", 2'b10, 1'b1, 4'hF, 1'b0, 1'b0);

    // Forced release of a sole requester and its regrant
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      check_all($sformatf("forced_grant%0d", i), 2'b00, 1'b0, 4'b1110, 1'b1, 1'b0);
    end
    step();
    check_all("forced_gap", 2'b00, 1'b1, 4'hF, 1'b1, 1'b1);
    step();
    check_all("forced_idle", 2'b00, 1'b1, 4'hF, 1'b0, 1'b0);
    step();
    check_all("forced_regrant", 2'b00, 1'b0, 4'b1110, 1'b1, 1'b0);

    // Round-robin rotation under full load, each owner timed out
    rst = 1'b1;
    req = 4'hF;
    step();
    rst = 1'b0;
    check_all("rr_reset", 2'b00, 1'b1, 4'hF, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) begin
        step();
        check_all($sformatf("rr%0d_grant%0d", k, i), order[k], 1'b0, gn_of(order[k]), 1'b1, 1'b0);
      end
      step();
      check_all($sformatf("rr%0d_gap", k), order[k], 1'b1, 4'hF, 1'b1, 1'b1);
      step();
      check_all($sformatf("rr%0d_idle", k), order[k], 1'b1, 4'hF, 1'b0, 1'b0);
    end

    // Owner drops its request on the same edge the hold limit hits
    for (int i = 0; i < 8; i++) begin
      step();
      check_all($sformatf("sim_grant%0d", i), 2'b01, 1'b0, 4'b1101, 1'b1, 1'b0);
    end
    req = 4'b1101;
    step();
    check_all("sim_gap", 2'b01, 1'b1, 4'hF, 1'b1, 1'b0);
    step();
    check_all("sim_idle", 2'b01, 1'b1, 4'hF, 1'b0, 1'b0);

    // Reset during owner 2's third grant cycle
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("mid_grant%0d", i), 2'b10, 1'b0, 4'b1011, 1'b1, 1'b0);
    end
    rst = 1'b1;
    req = 4'b0101;
    step();
    check_all("mid_reset", 2'b00, 1'b1, 4'hF, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_all("mid_regrant", 2'b00, 1'b0, 4'b1110, 1'b1, 1'b0);

    // Pointer must be back at 3: requesters 1 and 3 pending, 1 wins after 0
    req = 4'b1010;
    step();
    check_all("ptr_gap", 2'b00, 1'b1, 4'hF, 1'b1, 1'b0);
    step();
    step();
    check_all("ptr_next", 2'b01, 1'b0, 4'b1101, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
